// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, block width, round constants,
// GF(2^8) xtime and the forward S-box lookup.
package aes_pkg;
   localparam int NR    = 10;
   localparam int BLK_W = 128;

   // Indexed directly by the round counter (1..10); unused slots are zero.
   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] s;
      s = 8'h00;
      case (b)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      endcase
      return s;
   endfunction
endpackage

// File: rtl/aes_round.sv
// One combinational AES round plus on-the-fly key expansion step.
// Ports: state/round_key = current block and previous round key,
//   rcon = round constant, final_round = skip MixColumns,
//   next_state = round output (already keyed), next_key = this round's key.
module aes_round
   import aes_pkg::*;
(
   input  logic [BLK_W-1:0] state,
   input  logic [BLK_W-1:0] round_key,
   input  logic [7:0]       rcon,
   input  logic             final_round,
   output logic [BLK_W-1:0] next_state,
   output logic [BLK_W-1:0] next_key
);
   logic [7:0]  sb [16];
   logic [7:0]  sr [16];
   logic [7:0]  mc [16];
   logic [31:0] w  [4];
   logic [31:0] nw [4];
   logic [31:0] rot;
   logic [31:0] tmp;

   always_comb begin
      next_state = '0;
      // Byte i lives at row i%4, column i/4; byte 0 is the MSB.
      for (int i = 0; i < 16; i++) sb[i] = sbox(state[BLK_W-1-8*i -: 8]);
      // ShiftRows: row r rotates left by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[r+4*c] = sb[r + 4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      // Key expansion: word 0 gets RotWord/SubWord/Rcon, the rest chain.
      for (int i = 0; i < 4; i++) w[i] = round_key[BLK_W-1-32*i -: 32];
      rot = {w[3][23:0], w[3][31:24]};
      tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon, 24'h0};
      nw[0] = w[0] ^ tmp;
      nw[1] = w[1] ^ nw[0];
      nw[2] = w[2] ^ nw[1];
      nw[3] = w[3] ^ nw[2];
      next_key = {nw[0], nw[1], nw[2], nw[3]};
      for (int i = 0; i < 16; i++)
         next_state[BLK_W-1-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ next_key[BLK_W-1-8*i -: 8];
   end
endmodule

// File: rtl/aes_128_encryptor.sv
// Iterative AES-128 encryption core, one round per clock.
// Ports: clk, rst_n (async low), start (accepted when idle),
//   state/key (plaintext and key, byte 0 in MSBs), busy (run in progress),
//   done (one-cycle pulse on result), cipher (last result, held).
module aes_128_encryptor
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BLK_W-1:0] state,
   input  logic [BLK_W-1:0] key,
   output logic             busy,
   output logic             done,
   output logic [BLK_W-1:0] cipher
);
   logic [BLK_W-1:0] st_q, rk_q, nxt_state, nxt_key;
   logic [3:0]       round_q;
   logic             last;

   assign last = (round_q == 4'(NR));

   aes_round u_round (
      .state       (st_q),
      .round_key   (rk_q),
      .rcon        (RCON[round_q]),
      .final_round (last),
      .next_state  (nxt_state),
      .next_key    (nxt_key)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= '0;
         rk_q    <= '0;
         round_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cipher  <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            st_q <= nxt_state;
            rk_q <= nxt_key;
            if (last) begin
               cipher  <= nxt_state;
               done    <= 1'b1;
               busy    <= 1'b0;
               round_q <= '0;
            end else begin
               round_q <= round_q + 4'd1;
            end
         end else if (start) begin
            // Initial AddRoundKey happens at capture; key is round key 0.
            st_q    <= state ^ key;
            rk_q    <= key;
            round_q <= 4'd1;
            busy    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_aes_128_encryptor.sv
// Self-checking bench for aes_128_encryptor: directed FIPS-197 vectors,
// handshake corner cases, and random blocks against a byte-level model.
module tb_aes_128_encryptor;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [127:0] state = '0;
   logic [127:0] key = '0;
   logic         busy, done;
   logic [127:0] cipher;

   int total = 0;
   int bad = 0;
   logic [7:0] sbx [256];

   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_128_encryptor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .state(state), .key(key),
      .busy(busy), .done(done), .cipher(cipher));

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from its definition: GF inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] b;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbx[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      logic [127:0] out;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbx[tmp[31:24]], sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbx[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[row+4*c] = s[row + 4*((c+row)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
               s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end else begin
               for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [127:0] pt, input logic [127:0] k);
      state = pt; key = k; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Steps until done (bounded); n = edges after acceptance.
   task automatic wait_done(input bit scramble, output int n);
      n = 0;
      do begin
         if (scramble) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            key   = {$urandom, $urandom, $urandom, $urandom};
         end
         step();
         n++;
      end while (!done && n < 30);
   endtask

   initial begin
      int n, dones;
      logic [127:0] pt, k, exp, got;
      build_sbox();

      // Asynchronous reset, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 128'(busy), 128'h0);
      chk("rst_done", 128'(done), 128'h0);
      chk("rst_cipher", cipher, 128'h0);
      step(); step();
      rst_n = 1'b1;
      step();

      // App. B
      launch(PB, KB);
      chk("b_busy", 128'(busy), 128'h1);
      wait_done(1'b0, n);
      chk("b_latency", 128'(n), 128'd10);
      chk("b_cipher", cipher, CB);
      chk("b_busy_end", 128'(busy), 128'h0);
      step();
      chk("b_done_pulse", 128'(done), 128'h0);
      chk("b_hold", cipher, CB);

      // C.1 and all-zero
      launch(PC, KC);
      wait_done(1'b0, n);
      chk("c1_latency", 128'(n), 128'd10);
      chk("c1_cipher", cipher, CC);
      launch('0, '0);
      wait_done(1'b0, n);
      chk("zero_cipher", cipher, CZ);

      // start while busy is ignored
      launch(PB, KB);
      step(); step();
      state = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      step();
      start = 1'b0;
      dones = 0; got = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) begin dones++; got = cipher; end
      end
      chk("busy_ignore_dones", 128'(dones), 128'd1);
      chk("busy_ignore_cipher", got, CB);

      // start on the done cycle
      launch(PB, KB);
      wait_done(1'b0, n);
      chk("bb_first", cipher, CB);
      launch(PC, KC);
      chk("bb_busy", 128'(busy), 128'h1);
      chk("bb_hold", cipher, CB);
      wait_done(1'b0, n);
      chk("bb_latency", 128'(n), 128'd10);
      chk("bb_cipher", cipher, CC);

      // random blocks, half with inputs scrambled while busy
      for (int j = 0; j < 6; j++) begin
         pt  = {$urandom, $urandom, $urandom, $urandom};
         k   = {$urandom, $urandom, $urandom, $urandom};
         exp = aes_ref(pt, k);
         launch(pt, k);
         wait_done(j[0], n);
         chk("rnd_latency", 128'(n), 128'd10);
         chk("rnd_cipher", cipher, exp);
      end

      // reset mid-operation
      launch(PB, KB);
      step(); step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 128'(busy), 128'h0);
      chk("mid_rst_done", 128'(done), 128'h0);
      chk("mid_rst_cipher", cipher, 128'h0);
      step(); step();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done) dones++;
      end
      chk("mid_rst_no_done", 128'(dones), 128'd0);
      launch(PB, KB);
      wait_done(1'b0, n);
      chk("post_rst_latency", 128'(n), 128'd10);
      chk("post_rst_cipher", cipher, CB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
